dot_seq: RTL and testbench
==========================

Name: dot_seq

Overview:
- Operand sequencer and accumulator that sits directly upstream of the output/psum path of the MAC stage.
- Accepts one vector of LANES unsigned activations, LANES signed weights and an incoming partial sum via valid/ready.
- Performs one multiply-accumulate per cycle, lane 0 first, and presents the final psum with valid/ready.
- Replaces the bench-side loop that feeds x[i]/w[i] and psum_in into the MAC.

Parameters:
bw, 4, activation/weight width (activation unsigned, weight two's-complement signed)
psum_bw, 16, partial-sum / accumulator width (two's complement)
LANES, 4, elements per vector (>=1); lane counter width = max(1, $clog2(LANES))

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector (high only in IDLE)
x_vec  input  LANES*bw  activations; lane k = x_vec[k*bw +: bw], unsigned
w_vec  input  LANES*bw  weights; lane k = w_vec[k*bw +: bw], signed
psum_in  input  psum_bw  initial accumulator value
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  downstream accepts result
out  output  psum_bw  accumulated psum
busy  output  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out=0. Accumulator, lane counter and captured vectors are all 0.
- Handshakes are ignored while reset is high.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture x_vec, w_vec into registers; acc<=psum_in; lane<=0; go to RUN.
  - in_valid=0 -> stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: acc <= acc + zext(x[lane]) * sext(w[lane]); lane<=lane+1.
  - On the edge that processes lane LANES-1: lane<=0; go to DONE.
  - Exactly LANES RUN cycles, no stalls.
- DONE:
  - out_valid=1, out=acc, busy=1.
  - Edge with out_ready=1 -> IDLE. No new vector is accepted on that edge; the next accept is at the earliest edge after.
  - out_ready=0 -> hold; out and out_valid stay stable.
- Latency: accept edge E0; out_valid is high after edge E0+LANES. Throughput: one vector per LANES+2 cycles with out_ready tied high.
- Arithmetic:
  - Product is formed as signed (bw+1)x(bw) and sign-extended to psum_bw before the add.
  - Add is modulo 2^psum_bw; wrap silently, no saturation, no overflow flag.
- out is registered and equals acc. It reads acc in every state; only the DONE value is meaningful.
- in_valid asserted during RUN/DONE is ignored (in_ready=0). The upstream source must hold the vector until accepted.
- Inputs x_vec/w_vec/psum_in may change freely after the accept edge; only captured copies are used.
- Reset mid-RUN or mid-DONE aborts the operation. State returns to IDLE with all reset values above; no partial result is emitted.

Test Plan:
1. x=[1,2,3,4], w=[1,-1,2,-2], psum_in=0, out_ready=1 -> out=16'hFFFD (-3), out_valid for 1 cycle exactly 4 cycles after accept.
2. x=[15,15,15,15], w=[-8,-8,-8,-8], psum_in=16'h0010 -> out=16'hFE30 (-464). Checks signed extremes: unsigned activation max, weight min.
3. psum_in=16'h7FFF, x=[15,0,0,0], w=[7,0,0,0] -> out=16'h8068 (wrap, no saturation).
4. Backpressure: after case 1, hold out_ready=0 for 3 cycles -> out=16'hFFFD and out_valid stay stable, in_ready=0. A second in_valid during the hold is not accepted. Raise out_ready -> IDLE, then the second vector is accepted.
5. Reset asserted asynchronously during the 2nd RUN cycle -> out_valid=0, busy=0, out=0, in_ready=1 immediately. A new vector with x=[2,2,2,2], w=[3,3,3,3], psum_in=5 yields out=16'h001D (29).
6. Back-to-back stream of 5 random vectors with out_ready=1 -> each out matches the reference model sum(x[k]*w[k])+psum_in mod 2^16. Each accept is spaced by LANES+2 cycles.

Source files
------------

// File: rtl/dot_seq_if.sv
// Handshake and data bundle between the dot-product sequencer and its
// upstream vector source / downstream psum consumer.
interface dot_seq_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int LANES   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*bw-1:0]   x_vec;
  logic [LANES*bw-1:0]   w_vec;
  logic [psum_bw-1:0]    psum_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [psum_bw-1:0]    out;
  logic                  busy;

  modport master (
    output in_valid, x_vec, w_vec, psum_in, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, x_vec, w_vec, psum_in, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/dot_seq.sv
// Operand sequencer/accumulator: captures one vector, runs one signed
// MAC per cycle (lane 0 first) and holds the psum until it is taken.
module dot_seq #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int LANES   = 4
) (
  input  logic      clk,
  input  logic      reset,
  dot_seq_if.slave  bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LANES*bw-1:0]   x_q, w_q;
  logic [psum_bw-1:0]    acc_q;
  logic [LW-1:0]         lane_q;

  logic [bw-1:0]         x_lane, w_lane;
  logic signed [2*bw:0]  prod;
  logic [psum_bw-1:0]    prod_ext;
  logic                  last_lane;
  logic                  in_ready_c, out_valid_c, busy_c;

  always_comb begin
    x_lane = '0;
    w_lane = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        x_lane = x_q[k*bw +: bw];
        w_lane = w_q[k*bw +: bw];
      end
    end
  end

  // Activation gets a zero sign bit so the multiply is (bw+1)x(bw) signed.
  assign prod      = $signed({1'b0, x_lane}) * $signed(w_lane);
  assign prod_ext  = psum_bw'(prod);
  assign last_lane = (lane_q == LW'(LANES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_lane) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      w_q    <= '0;
      acc_q  <= '0;
      lane_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q    <= bus.x_vec;
            w_q    <= bus.w_vec;
            acc_q  <= bus.psum_in;
            lane_q <= '0;
          end
        end
        RUN: begin
          acc_q  <= acc_q + prod_ext;
          lane_q <= last_lane ? '0 : lane_q + LW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out       = acc_q;

endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq: arithmetic cases, backpressure, async reset
// abort and a back-to-back stream against an integer reference.
module tb_dot_seq;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LANES   = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dot_seq_if #(.bw(BW), .psum_bw(PSUM_BW), .LANES(LANES)) bus ();

  dot_seq #(.bw(BW), .psum_bw(PSUM_BW), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [LANES*BW-1:0] pack4(input int a, input int b,
                                                input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  // Drives one vector from a negedge and checks the whole transaction:
  // out_valid rises exactly LANES edges after accept and lasts one cycle.
  task automatic do_vector(input string name, input logic [LANES*BW-1:0] xv,
                           input logic [LANES*BW-1:0] wv,
                           input logic [PSUM_BW-1:0] p,
                           input logic [PSUM_BW-1:0] exp_out);
    bus.x_vec     = xv;
    bus.w_vec     = wv;
    bus.psum_in   = p;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x_vec    = '0;
    bus.w_vec    = '0;
    bus.psum_in  = '1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept busy=%b in_ready=%b required busy=1 in_ready=0",
               name, bus.busy, bus.in_ready);
    end
    for (int k = 1; k <= LANES; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== (k == LANES)) begin
        n_fail++;
        $display("FAIL %s_latency cycle %0d out_valid=%b required %b",
                 name, k, bus.out_valid, (k == LANES));
      end
    end
    n_checks++;
    if (bus.out !== exp_out) begin
      n_fail++;
      $display("FAIL %s_out out=%h required %h", name, bus.out, exp_out);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release out_valid=%b in_ready=%b busy=%b required 0 1 0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.x_vec     = pack4(1, 1, 1, 1);
    bus.w_vec     = pack4(1, 1, 1, 1);
    bus.psum_in   = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b out=%h required 1 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.out);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    do_vector("basic", pack4(1, 2, 3, 4), pack4(1, -1, 2, -2), 16'h0000, 16'hFFFD);
  endtask

  task automatic test_extremes();
    do_vector("extremes", pack4(15, 15, 15, 15), pack4(-8, -8, -8, -8), 16'h0010, 16'hFE30);
  endtask

  task automatic test_wrap();
    do_vector("wrap", pack4(15, 0, 0, 0), pack4(7, 0, 0, 0), 16'h7FFF, 16'h8068);
  endtask

  task automatic test_backpressure();
    bus.x_vec     = pack4(1, 2, 3, 4);
    bus.w_vec     = pack4(1, -1, 2, -2);
    bus.psum_in   = 16'h0000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.x_vec   = pack4(1, 1, 1, 1);
    bus.w_vec   = pack4(1, 1, 1, 1);
    bus.psum_in = 16'h0000;
    repeat (LANES) @(negedge clk);
    for (int h = 0; h < 4; h++) begin
      n_checks++;
      if (bus.out !== 16'hFFFD || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d out=%h out_valid=%b in_ready=%b required FFFD 1 0",
                 h, bus.out, bus.out_valid, bus.in_ready);
      end
      if (h < 3) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_accept busy=%b required 1", bus.busy);
    end
    repeat (LANES) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 16'h0004) begin
      n_fail++;
      $display("FAIL bp_second_out out_valid=%b out=%h required 1 0004",
               bus.out_valid, bus.out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bus.x_vec     = pack4(1, 2, 3, 4);
    bus.w_vec     = pack4(1, -1, 2, -2);
    bus.psum_in   = 16'h0100;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 16'h0000 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset out_valid=%b busy=%b out=%h in_ready=%b required 0 0 0000 1",
               bus.out_valid, bus.busy, bus.out, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result out_valid=%b busy=%b required 0 0",
               bus.out_valid, bus.busy);
    end
    do_vector("after_abort", pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 16'h0005, 16'h001D);
  endtask

  task automatic test_back_to_back();
    logic [LANES*BW-1:0] xs [5];
    logic [LANES*BW-1:0] ws [5];
    logic [PSUM_BW-1:0]  ps [5];
    logic [PSUM_BW-1:0]  exp_out;
    int                  prev_acc, acc_cyc, t, sum, xv, wv;
    logic [BW-1:0]       nib;
    for (int i = 0; i < 5; i++) begin
      xs[i] = LANES*BW'($urandom());
      ws[i] = LANES*BW'($urandom());
      ps[i] = PSUM_BW'($urandom());
    end
    prev_acc      = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x_vec     = xs[0];
    bus.w_vec     = ws[0];
    bus.psum_in   = ps[0];
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t == 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_accept_timeout vec %0d in_ready=%b required 1", i, bus.in_ready);
      end
      acc_cyc = cyc;
      if (i > 0) begin
        n_checks++;
        if (acc_cyc - prev_acc !== LANES + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing vec %0d spacing=%0d required %0d",
                   i, acc_cyc - prev_acc, LANES + 2);
        end
      end
      prev_acc = acc_cyc;
      sum = int'(ps[i]);
      for (int k = 0; k < LANES; k++) begin
        nib = xs[i][k*BW +: BW];
        xv  = int'(nib);
        nib = ws[i][k*BW +: BW];
        wv  = (nib >= 8) ? int'(nib) - 16 : int'(nib);
        sum = sum + xv * wv;
      end
      exp_out = PSUM_BW'(sum);
      @(negedge clk);
      if (i < 4) begin
        bus.x_vec   = xs[i+1];
        bus.w_vec   = ws[i+1];
        bus.psum_in = ps[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp_out) begin
        n_fail++;
        $display("FAIL b2b_out vec %0d out_valid=%b out=%h required 1 %h",
                 i, bus.out_valid, bus.out, exp_out);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_vec     = '0;
    bus.w_vec     = '0;
    bus.psum_in   = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
